// File: rtl/anton_neopixel_decoder.sv
// anton_neopixel_decoder: recovers 24-bit pixels, frame ends and line errors from a sampled NeoPixel line
module anton_neopixel_decoder #(
  parameter int HIGH_THRESHOLD = 4,
  parameter int MAX_HIGH = 7,
  parameter int RESET_TICKS = 350,
  parameter int INDEX_BITS = 16
) (
  input  logic                  clk7mhz,
  input  logic                  resetn,
  input  logic                  neoData,
  output logic [23:0]           pixelData,
  output logic [INDEX_BITS-1:0] pixelIndex,
  output logic                  pixelValid,
  input  logic                  pixelReady,
  output logic                  frameEnd,
  output logic [INDEX_BITS-1:0] frameCount,
  output logic                  errPulse,
  output logic                  errPartial,
  output logic                  errOverflow,
  input  logic                  errClear
);
  localparam int HW = $clog2(MAX_HIGH + 2);
  localparam int LW = $clog2(RESET_TICKS + 1);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state, state_n;
  logic d_q;
  logic [HW-1:0] hi_cnt, hi_cnt_n;
  logic [LW-1:0] lo_cnt, lo_cnt_n;
  logic [4:0] bit_cnt, bit_cnt_n;
  logic [23:0] shift, shift_n;
  logic [INDEX_BITS-1:0] pix_cnt, pix_cnt_n;
  logic decode, bad, done, load, fend;
  always_comb begin
    state_n = state;
    hi_cnt_n = hi_cnt;
    lo_cnt_n = lo_cnt;
    bit_cnt_n = bit_cnt;
    shift_n = shift;
    pix_cnt_n = pix_cnt;
    decode = state == HIGH && !d_q;
    bad = decode && hi_cnt > HW'(MAX_HIGH);
    done = decode && !bad && bit_cnt == 5'd23;
    load = done && (!pixelValid || pixelReady);
    fend = state == LOW && !d_q && lo_cnt == LW'(RESET_TICKS - 1);
    if (d_q) begin
      state_n = HIGH;
      hi_cnt_n = state != HIGH ? HW'(1) : hi_cnt == HW'(MAX_HIGH + 1) ? hi_cnt : hi_cnt + 1'b1;
    end else if (decode) begin
      state_n = LOW;
      lo_cnt_n = LW'(1);
      shift_n[bit_cnt] = hi_cnt >= HW'(HIGH_THRESHOLD);
      bit_cnt_n = bad || done ? '0 : bit_cnt + 1'b1;
      pix_cnt_n = done && !(&pix_cnt) ? pix_cnt + 1'b1 : pix_cnt;
    end else if (state == LOW) begin
      state_n = fend ? IDLE : LOW;
      lo_cnt_n = fend ? '0 : lo_cnt + 1'b1;
      bit_cnt_n = fend ? '0 : bit_cnt;
      pix_cnt_n = fend ? '0 : pix_cnt;
    end
  end
  always_ff @(posedge clk7mhz) begin
    if (!resetn) begin
      d_q <= 1'b0;
      state <= IDLE;
      hi_cnt <= '0;
      lo_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      pix_cnt <= '0;
      pixelData <= '0;
      pixelIndex <= '0;
      pixelValid <= 1'b0;
      frameEnd <= 1'b0;
      frameCount <= '0;
      errPulse <= 1'b0;
      errPartial <= 1'b0;
      errOverflow <= 1'b0;
    end else begin
      d_q <= neoData;
      state <= state_n;
      hi_cnt <= hi_cnt_n;
      lo_cnt <= lo_cnt_n;
      bit_cnt <= bit_cnt_n;
      shift <= shift_n;
      pix_cnt <= pix_cnt_n;
      pixelData <= load ? shift_n : pixelData;
      pixelIndex <= load ? pix_cnt : pixelIndex;
      pixelValid <= load || (pixelValid && !pixelReady);
      frameEnd <= fend;
      frameCount <= fend ? pix_cnt : frameCount;
      errPulse <= bad || (errPulse && !errClear);
      errPartial <= (fend && bit_cnt != '0) || (errPartial && !errClear);
      errOverflow <= (done && !load) || (errOverflow && !errClear);
    end
  end
endmodule

// File: tb/tb_anton_neopixel_decoder.sv
// tb_anton_neopixel_decoder: directed and randomized frames checked against a symbol-level pixel model
module tb_anton_neopixel_decoder;
  logic clk7mhz = 0, resetn = 0, neoData = 0, pixelReady = 1, errClear = 0;
  logic [23:0] pixelData;
  logic [15:0] pixelIndex, frameCount;
  logic pixelValid, frameEnd, errPulse, errPartial, errOverflow;
  int passed = 0, total = 0, failed = 0, fe_n = 0;
  logic [15:0] fe_cnt = 0;
  logic [23:0] got_d[$], exp_d[$];
  logic [15:0] got_i[$], exp_i[$];

  always #5 clk7mhz = ~clk7mhz;

  anton_neopixel_decoder dut (
    .clk7mhz(clk7mhz), .resetn(resetn), .neoData(neoData),
    .pixelData(pixelData), .pixelIndex(pixelIndex), .pixelValid(pixelValid),
    .pixelReady(pixelReady), .frameEnd(frameEnd), .frameCount(frameCount),
    .errPulse(errPulse), .errPartial(errPartial), .errOverflow(errOverflow),
    .errClear(errClear)
  );

  always @(negedge clk7mhz) if (resetn) begin
    if (pixelValid && pixelReady) begin
      got_d.push_back(pixelData);
      got_i.push_back(pixelIndex);
    end
    if (frameEnd) begin
      fe_n++;
      fe_cnt = frameCount;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      neoData = v;
      @(posedge clk7mhz);
      #1;
    end
  endtask

  task automatic pulse(input int h, input int l);
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic send_range(input logic [23:0] w, input int lo, input int hi);
    for (int i = lo; i < hi; i++) pulse(w[i] ? 5 : 2, w[i] ? 3 : 6);
  endtask

  task automatic clear_flags();
    errClear = 1;
    drive(1'b0, 1);
    errClear = 0;
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_beats"}, 32'(got_d.size()), 32'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk({tag, "_data"}, 32'(got_d[i]), 32'(exp_d[i]));
      chk({tag, "_index"}, 32'(got_i[i]), 32'(exp_i[i]));
    end
    got_d.delete();
    got_i.delete();
    exp_d.delete();
    exp_i.delete();
  endtask

  task automatic frame_ok(input string tag, input logic [23:0] w[$]);
    int fe0 = fe_n;
    foreach (w[i]) begin
      send_range(w[i], 0, 24);
      exp_d.push_back(w[i]);
      exp_i.push_back(16'(i));
    end
    drive(1'b0, 420);
    check_beats(tag);
    chk({tag, "_frame_ends"}, 32'(fe_n - fe0), 32'd1);
    chk({tag, "_frame_count"}, 32'(fe_cnt), 32'(w.size()));
  endtask

  function automatic void rand_frame(output logic [23:0] w[$], input int n);
    w.delete();
    for (int i = 0; i < n; i++) w.push_back(24'($urandom));
  endfunction

  initial begin
    logic [23:0] w[$];
    logic [23:0] x, y;
    int fe0;
    repeat (3) @(posedge clk7mhz);
    #1;
    chk("rst_valid", 32'(pixelValid), 0);
    chk("rst_data", 32'(pixelData), 0);
    chk("rst_index", 32'(pixelIndex), 0);
    chk("rst_frame", 32'({frameEnd, frameCount}), 0);
    chk("rst_err", 32'({errPulse, errPartial, errOverflow}), 0);
    resetn = 1;
    drive(1'b0, 4);
    // normal frames with the consumer always ready
    w = {24'hFF00D5, 24'h008800, 24'h000090};
    frame_ok("t1", w);
    chk("t1_err", 32'({errPulse, errPartial, errOverflow}), 0);
    rand_frame(w, $urandom_range(2, 5));
    frame_ok("t1_rand", w);
    // stalled consumer: first pixel held, later ones overflow
    pixelReady = 0;
    fe0 = fe_n;
    w = {24'hFF00D5, 24'h008800, 24'h000090};
    foreach (w[i]) send_range(w[i], 0, 24);
    drive(1'b0, 420);
    chk("t2_stalled_beats", 32'(got_d.size()), 0);
    chk("t2_held_valid", 32'(pixelValid), 1);
    chk("t2_overflow", 32'(errOverflow), 1);
    chk("t2_frame_ends", 32'(fe_n - fe0), 1);
    chk("t2_frame_count", 32'(frameCount), 3);
    pixelReady = 1;
    exp_d.push_back(24'hFF00D5);
    exp_i.push_back(16'd0);
    drive(1'b0, 3);
    check_beats("t2_release");
    chk("t2_valid_cleared", 32'(pixelValid), 0);
    clear_flags();
    chk("t2_cleared", 32'({errPulse, errPartial, errOverflow}), 0);
    rand_frame(w, $urandom_range(1, 4));
    frame_ok("t2_next", w);
    // threshold boundaries: 3 high ticks is '0', 4 is '1'
    x = 24'($urandom);
    x[1:0] = 2'b10;
    pulse(3, 5);
    pulse(4, 4);
    send_range(x, 2, 24);
    exp_d.push_back(x);
    exp_i.push_back(16'd0);
    drive(1'b0, 420);
    check_beats("t3_threshold");
    chk("t3_no_pulse_err", 32'(errPulse), 0);
    // 8-tick high pulse discards pending bits
    fe0 = fe_n;
    x = 24'($urandom);
    y = 24'($urandom);
    send_range(x, 0, 5);
    pulse(8, 3);
    send_range(y, 0, 24);
    exp_d.push_back(y);
    exp_i.push_back(16'd0);
    drive(1'b0, 420);
    check_beats("t3_after_err");
    chk("t3_pulse_err", 32'(errPulse), 1);
    chk("t3_no_partial", 32'(errPartial), 0);
    chk("t3_frame_count", 32'(fe_cnt), 1);
    chk("t3_frame_ends", 32'(fe_n - fe0), 1);
    // partial frame
    clear_flags();
    fe0 = fe_n;
    x = 24'($urandom);
    send_range(x, 0, 10);
    drive(1'b0, 360);
    check_beats("t4_no_pixel");
    chk("t4_frame_ends", 32'(fe_n - fe0), 1);
    chk("t4_partial", 32'(errPartial), 1);
    chk("t4_frame_count", 32'(fe_cnt), 0);
    clear_flags();
    chk("t4_cleared", 32'({errPulse, errPartial, errOverflow}), 0);
    // 349 low ticks inside a pixel is not a frame end
    fe0 = fe_n;
    x = 24'($urandom);
    send_range(x, 0, 11);
    pulse(x[11] ? 5 : 2, 349);
    chk("t5_349_no_end", 32'(fe_n - fe0), 0);
    send_range(x, 12, 24);
    exp_d.push_back(x);
    exp_i.push_back(16'd0);
    drive(1'b0, 420);
    check_beats("t5_349");
    chk("t5_349_frame_ends", 32'(fe_n - fe0), 1);
    chk("t5_349_partial", 32'(errPartial), 0);
    // exactly 350 low ticks ends the frame
    fe0 = fe_n;
    send_range(x, 0, 11);
    pulse(x[11] ? 5 : 2, 350);
    drive(1'b1, 2);
    chk("t5_350_end", 32'(fe_n - fe0), 1);
    chk("t5_350_partial", 32'(errPartial), 1);
    drive(1'b0, 360);
    check_beats("t5_350");
    // reset in the middle of a pixel with a held word and sticky flags
    pixelReady = 0;
    x = 24'($urandom);
    y = 24'($urandom);
    send_range(x, 0, 24);
    send_range(y, 0, 12);
    chk("t6_held_before", 32'(pixelValid), 1);
    resetn = 0;
    drive(1'b0, 1);
    chk("t6_valid", 32'(pixelValid), 0);
    chk("t6_data", 32'({pixelData, pixelIndex}), 0);
    chk("t6_frame", 32'({frameEnd, frameCount}), 0);
    chk("t6_err", 32'({errPulse, errPartial, errOverflow}), 0);
    resetn = 1;
    pixelReady = 1;
    got_d.delete();
    got_i.delete();
    drive(1'b0, 2);
    rand_frame(w, $urandom_range(2, 4));
    frame_ok("t6_after", w);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
